// File: rtl/rv_pipe_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, control encodings, the main
// decoder and the 32-bit immediate extender used by the decode stage.
package rv_pipe_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultSrcT;

    // LUI passes SrcB through; AUIPC adds the immediate to the PC.
    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_LUI   = 3'b110,
        ALU_AUIPC = 3'b111
    } aluCtrlT;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immSrcT;

    typedef struct packed {
        logic      regWrite;
        logic      memWrite;
        logic      jump;
        logic      jalr;
        logic      branch;
        logic      aluSrc;
        aluCtrlT   aluControl;
        resultSrcT resultSrc;
        immSrcT    immSrc;
        logic      rs2Used;
    } ctrlT;

    function automatic aluCtrlT aluDecode(input logic [2:0] funct3, input logic funct7b5,
                                          input logic isR);
        case (funct3)
            3'b000:  return (isR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // Unknown opcodes leave every control at zero so they retire as a NOP.
    function automatic ctrlT decodeCtrl(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic funct7b5);
        ctrlT c;
        c = '0;
        case (opcode)
            OP_LOAD: begin
                c.regWrite  = 1'b1;
                c.aluSrc    = 1'b1;
                c.resultSrc = RES_MEM;
            end
            OP_S: begin
                c.memWrite = 1'b1;
                c.aluSrc   = 1'b1;
                c.immSrc   = IMM_S;
                c.rs2Used  = 1'b1;
            end
            OP_R: begin
                c.regWrite   = 1'b1;
                c.rs2Used    = 1'b1;
                c.aluControl = aluDecode(funct3, funct7b5, 1'b1);
            end
            OP_I: begin
                c.regWrite   = 1'b1;
                c.aluSrc     = 1'b1;
                c.aluControl = aluDecode(funct3, funct7b5, 1'b0);
            end
            OP_B: begin
                c.branch     = 1'b1;
                c.immSrc     = IMM_B;
                c.aluControl = ALU_SUB;
                c.rs2Used    = 1'b1;
            end
            OP_JAL: begin
                c.regWrite  = 1'b1;
                c.jump      = 1'b1;
                c.resultSrc = RES_PC4;
                c.immSrc    = IMM_J;
            end
            OP_JALR: begin
                c.regWrite  = 1'b1;
                c.jump      = 1'b1;
                c.jalr      = 1'b1;
                c.aluSrc    = 1'b1;
                c.resultSrc = RES_PC4;
            end
            OP_LUI: begin
                c.regWrite   = 1'b1;
                c.aluSrc     = 1'b1;
                c.immSrc     = IMM_U;
                c.aluControl = ALU_LUI;
            end
            OP_AUIPC: begin
                c.regWrite   = 1'b1;
                c.aluSrc     = 1'b1;
                c.immSrc     = IMM_U;
                c.aluControl = ALU_AUIPC;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] immExtend32(input logic [31:7] ins, input immSrcT src);
        case (src)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: reset > flush > stall (hold) > bubble > load.
module id_ex_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/decode_stage_hz.sv
// Parametrised decode stage with ID/EX register and load-use hazard detection.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into the reads.
module decode_stage_hz
    import rv_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            jalrE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [1:0]      ResultSrcE,
    output logic            LoadStallD
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int EW = 5 * XLEN + 27;

    logic [4:0]      rs1D;
    logic [4:0]      rs2D;
    logic [4:0]      rdD;
    ctrlT            ctrlD;
    logic [10:0]     ctlD;
    logic [XLEN-1:0] immExtD;
    logic [XLEN-1:0] rd1D;
    logic [XLEN-1:0] rd2D;
    logic [XLEN-1:0] regs [NREG];
    logic            hz;
    logic [EW-1:0]   eNext;
    logic [EW-1:0]   eReg;

    assign rs1D  = InstrD[19:15];
    assign rs2D  = InstrD[24:20];
    assign rdD   = InstrD[11:7];
    assign ctrlD = decodeCtrl(InstrD[6:0], InstrD[14:12], InstrD[30]);
    assign immExtD = XLEN'($signed(immExtend32(InstrD[31:7], ctrlD.immSrc)));

    function automatic logic inRange(input logic [4:0] idx);
        return int'(idx) < NREG;
    endfunction

    function automatic logic [XLEN-1:0] readPort(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != 5'd0 && inRange(idx)) begin
            v = regs[idx[IW-1:0]];
        end
`ifdef DECODE_WB_BYPASS_EN
        if (RegWriteW && RdW != 5'd0 && RdW == idx && inRange(RdW)) begin
            v = ResultW;
        end
`endif
        return v;
    endfunction

    // Register contents survive reset; x0 and out-of-range indices are never stored.
    always_ff @(posedge clk) begin
        if (RegWriteW && RdW != 5'd0 && inRange(RdW)) begin
            regs[RdW[IW-1:0]] <= ResultW;
        end
    end

    always_comb begin
        rd1D = readPort(rs1D);
        rd2D = readPort(rs2D);
    end

    // An invalid D slot enters E as a bubble even though its data fields are captured.
    assign ctlD = ValidD ? {ctrlD.regWrite, ctrlD.memWrite, ctrlD.jump, ctrlD.jalr,
                            ctrlD.branch, ctrlD.aluSrc, ctrlD.aluControl, ctrlD.resultSrc}
                         : 11'd0;

    assign eNext = {ValidD, ctlD, rs1D, rs2D, rdD, rd1D, rd2D, immExtD, PCD, PCPlus4D};

    assign hz = ValidE && (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                ((RdE == rs1D) || ((RdE == rs2D) && ctrlD.rs2Used));
    assign LoadStallD = hz && !FlushE && !StallE;

    id_ex_reg #(
        .W(EW)
    ) uIdEx (
        .clk   (clk),
        .rst   (rst),
        .flush (FlushE),
        .stall (StallE),
        .bubble(LoadStallD),
        .d     (eNext),
        .q     (eReg)
    );

    assign {ValidE, RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE, ALUControlE,
            ResultSrcE, Rs1E, Rs2E, RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E} = eReg;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz (RV32E configuration): vector table plus
// hand-written reset, load-use, flush, stall and bypass sequences.
module tb_decode_stage_hz;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD, PCPlus4D;
    logic            ValidD;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            StallE, FlushE;
    logic [XLEN-1:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            ValidE, RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
    logic [2:0]      ALUControlE;
    logic [1:0]      ResultSrcE;
    logic            LoadStallD;
    logic [10:0]     ctlE;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam logic [31:0] I_ADDI5  = 32'h00700293;  // addi x5,x0,7
    localparam logic [31:0] I_ADD    = 32'h001303B3;  // add x7,x6,x1
    localparam logic [31:0] I_SUB    = 32'h40418433;  // sub x8,x3,x4
    localparam logic [31:0] I_LW6    = 32'h00012303;  // lw x6,0(x2)
    localparam logic [31:0] I_LW0    = 32'h00012003;  // lw x0,0(x2)
    localparam logic [31:0] I_SW6    = 32'h00612023;  // sw x6,0(x2)
    localparam logic [31:0] I_ADDI76 = 32'h00600393;  // addi x7,x0,6
    localparam logic [31:0] I_ADD0   = 32'h001003B3;  // add x7,x0,x1
    localparam logic [31:0] I_ADDI61 = 32'h00100313;  // addi x6,x0,1
    localparam logic [31:0] I_LUI    = 32'hABCDE4B7;
    localparam logic [31:0] I_JAL    = 32'h010000EF;

    localparam logic [10:0] C_ADDI = 11'b1_0_0_0_0_1_000_00;
    localparam logic [10:0] C_SUB  = 11'b1_0_0_0_0_0_001_00;
    localparam logic [10:0] C_LW   = 11'b1_0_0_0_0_1_000_01;

    assign ctlE = {RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE, ALUControlE, ResultSrcE};

    always #5 clk = ~clk;

    decode_stage_hz #(
        .XLEN(XLEN),
        .NREG(16)
    ) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .jalrE(jalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE), .LoadStallD(LoadStallD)
    );

    typedef struct {
        logic [31:0] instr;
        logic        validD;
        logic        chkImm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm, rd1, rd2;
        logic [10:0] ctl;
        logic        expValid;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Puts instrL into E (after clearing E), presents instrX in D, checks LoadStallD.
    task automatic hazardCase(input string name, input logic [31:0] instrL, input logic validL,
                              input logic [31:0] instrX, input logic expStall);
        InstrD = 32'h0; ValidD = 1'b0;
        tick();
        InstrD = instrL; ValidD = validL;
        tick();
        InstrD = instrX; ValidD = 1'b1;
        #1;
        check(name, LoadStallD, expStall);
        $display("hazard %s: E=%08h D=%08h stall=%0b", name, instrL, instrX, LoadStallD);
    endtask

    initial begin
        rst = 1'b1; InstrD = I_ADDI5; ValidD = 1'b1; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; StallE = 1'b0; FlushE = 1'b0;

        // Reset held two cycles
        tick(); tick();
        check("rst_valid", ValidE, 1'b0);
        check("rst_ctl", ctlE, 11'd0);
        check("rst_idx", {Rs1E, Rs2E, RdE}, 15'd0);
        check("rst_rd", {RD1_E, RD2_E}, 64'd0);
        check("rst_imm", ImmExtE, 32'd0);
        check("rst_pc", {PCE, PCPlus4E}, 64'd0);
        check("rst_stall", LoadStallD, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_rd", RdE, 5'd5);
        check("post_rst_imm", ImmExtE, 32'd7);
        check("post_rst_ctl", {RegWriteE, ALUSrcE}, 2'b11);
        check("post_rst_valid", ValidE, 1'b1);
        $display("reset sequence done");

        // Preload x1..x15 = 0x1000+i; also attempt writes to x0 and x20
        InstrD = 32'h0; ValidD = 1'b0;
        for (int i = 1; i < 16; i++) begin
            RegWriteW = 1'b1; RdW = 5'(i); ResultW = 32'h1000 + i;
            tick();
        end
        RdW = 5'd0;  ResultW = 32'hDEAD; tick();
        RdW = 5'd20; ResultW = 32'hBEEF; tick();
        RegWriteW = 1'b0;

        // instr, validD, chkImm, rs1, rs2, rd, imm, rd1, rd2, ctl, expValid
        vecs.push_back('{I_ADDI5,      1, 1, 0, 7, 5, 32'h7, 32'h0, 32'h1007, C_ADDI, 1});
        vecs.push_back('{I_ADD,        1, 0, 6, 1, 7, 32'h0, 32'h1006, 32'h1001, 11'b1_0_0_0_0_0_000_00, 1});
        vecs.push_back('{I_SUB,        1, 0, 3, 4, 8, 32'h0, 32'h1003, 32'h1004, C_SUB, 1});
        vecs.push_back('{I_LW6,        1, 1, 2, 0, 6, 32'h0, 32'h1002, 32'h0, C_LW, 1});
        vecs.push_back('{32'h00512423, 1, 1, 2, 5, 8, 32'h8, 32'h1002, 32'h1005, 11'b0_1_0_0_0_1_000_00, 1});
        vecs.push_back('{32'hFE208EE3, 1, 1, 1, 2, 29, 32'hFFFFFFFC, 32'h1001, 32'h1002, 11'b0_0_0_0_1_0_001_00, 1});
        vecs.push_back('{I_JAL,        1, 1, 0, 16, 1, 32'h10, 32'h0, 32'h0, 11'b1_0_1_0_0_0_000_10, 1});
        vecs.push_back('{32'h00008067, 1, 1, 1, 0, 0, 32'h0, 32'h1001, 32'h0, 11'b1_0_1_1_0_1_000_10, 1});
        vecs.push_back('{I_LUI,        1, 1, 27, 28, 9, 32'hABCDE000, 32'h0, 32'h0, 11'b1_0_0_0_0_1_110_00, 1});
        vecs.push_back('{32'h00001517, 1, 1, 0, 0, 10, 32'h1000, 32'h0, 32'h0, 11'b1_0_0_0_0_1_111_00, 1});
        vecs.push_back('{32'h0000000B, 1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 11'd0, 1});
        vecs.push_back('{32'hFFF6F613, 1, 1, 13, 31, 12, 32'hFFFFFFFF, 32'h100D, 32'h0, 11'b1_0_0_0_0_1_010_00, 1});
        vecs.push_back('{32'h000A0293, 1, 1, 20, 0, 5, 32'h0, 32'h0, 32'h0, C_ADDI, 1});
        vecs.push_back('{I_ADD,        0, 0, 6, 1, 7, 32'h0, 32'h1006, 32'h1001, 11'd0, 0});

        foreach (vecs[i]) begin
            InstrD = vecs[i].instr; ValidD = vecs[i].validD;
            PCD = 32'h1000 + 32'(i * 8); PCPlus4D = PCD + 32'd4;
            #1;
            check($sformatf("v%0d_stall", i), LoadStallD, 1'b0);
            tick();
            check($sformatf("v%0d_valid", i), ValidE, vecs[i].expValid);
            check($sformatf("v%0d_idx", i), {Rs1E, Rs2E, RdE}, {vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
            if (vecs[i].chkImm) check($sformatf("v%0d_imm", i), ImmExtE, vecs[i].imm);
            check($sformatf("v%0d_rd1", i), RD1_E, vecs[i].rd1);
            check($sformatf("v%0d_rd2", i), RD2_E, vecs[i].rd2);
            check($sformatf("v%0d_ctl", i), ctlE, vecs[i].ctl);
            check($sformatf("v%0d_pc", i), {PCE, PCPlus4E}, {32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8)});
            $display("vec %0d: instr=%08h validE=%0b ctl=%03h imm=%08h", i, vecs[i].instr, ValidE, ctlE, ImmExtE);
        end

        // Hazard detection boundaries
        hazardCase("hz_rs2_store", I_LW6, 1'b1, I_SW6, 1'b1);
        hazardCase("hz_rs2_unused", I_LW6, 1'b1, I_ADDI76, 1'b0);
        hazardCase("hz_rd_x0", I_LW0, 1'b1, I_ADD0, 1'b0);
        hazardCase("hz_not_load", I_ADDI61, 1'b1, I_ADD, 1'b0);
        hazardCase("hz_invalid_e", I_LW6, 1'b0, I_ADD, 1'b0);

        // Load-use: bubble then the held add enters E
        hazardCase("lu_stall", I_LW6, 1'b1, I_ADD, 1'b1);
        tick();
        check("lu_bubble_valid", ValidE, 1'b0);
        check("lu_bubble_regwrite", RegWriteE, 1'b0);
        check("lu_bubble_stall_clear", LoadStallD, 1'b0);
        tick();
        check("lu_add_valid", ValidE, 1'b1);
        check("lu_add_rs", {Rs1E, Rs2E, RdE}, {5'd6, 5'd1, 5'd7});
        check("lu_add_rd1", RD1_E, 32'h1006);
        $display("load-use sequence done");

        // Flush beats the hazard
        hazardCase("fl_pre", I_LW6, 1'b1, I_ADD, 1'b1);
        FlushE = 1'b1;
        #1;
        check("fl_stall_masked", LoadStallD, 1'b0);
        tick();
        FlushE = 1'b0;
        check("fl_valid", ValidE, 1'b0);
        check("fl_ctl", ctlE, 11'd0);
        check("fl_fields", {Rs1E, Rs2E, RdE, ImmExtE}, 47'd0);
        $display("flush sequence done");

        // Stall with pending hazard: masked, then re-evaluated from held E
        hazardCase("st_pre", I_LW6, 1'b1, I_ADD, 1'b1);
        StallE = 1'b1;
        #1;
        check("st_stall_masked", LoadStallD, 1'b0);
        tick();
        check("st_held_load", {RdE, ctlE}, {5'd6, C_LW});
        StallE = 1'b0;
        #1;
        check("st_reeval", LoadStallD, 1'b1);
        InstrD = 32'h0; ValidD = 1'b0;
        tick();

        // Stall three cycles while D changes
        InstrD = I_ADDI5; ValidD = 1'b1; PCD = 32'h2000; PCPlus4D = 32'h2004;
        tick();
        StallE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: InstrD = I_SUB;
                1: InstrD = I_LUI;
                default: InstrD = I_JAL;
            endcase
            PCD = 32'h3000 + 32'(k * 4); PCPlus4D = PCD + 32'd4;
            tick();
            check($sformatf("stall%0d_fields", k), {RdE, ImmExtE, PCE}, {5'd5, 32'd7, 32'h2000});
            check($sformatf("stall%0d_ctl", k), {ValidE, ctlE}, {1'b1, C_ADDI});
            $display("stall cycle %0d: RdE=%0d ImmExtE=%08h", k, RdE, ImmExtE);
        end
        StallE = 1'b0; InstrD = I_SUB; PCD = 32'h4000; PCPlus4D = 32'h4004;
        tick();
        check("stall_resume", {RdE, ctlE, PCE}, {5'd8, C_SUB, 32'h4000});

        // Same-cycle writeback to a source register
        InstrD = 32'h0; ValidD = 1'b0;
        tick();
        InstrD = I_ADD; ValidD = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd6; ResultW = 32'h1234;
        tick();
`ifdef DECODE_WB_BYPASS_EN
        check("bypass_rd1", RD1_E, 32'h1234);
`else
        check("bypass_rd1", RD1_E, 32'h1006);
`endif
        check("bypass_rd2", RD2_E, 32'h1001);
        RegWriteW = 1'b0;
        tick();
        check("bypass_after_write", RD1_E, 32'h1234);
        $display("bypass sequence done: RD1_E=%08h", RD1_E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
